button_ctrl: RTL and testbench
==============================

# button_ctrl

Front-panel button conditioner placed directly upstream of the LED counter stage. Synchronises and debounces two raw pushbuttons (run, direction) and converts clean presses into the level controls the counter consumes: a run/stop `enable` and an up/down `dir`. With the long-press option it also issues a one-cycle `clr` pulse. That pulse is OR-ed into the counter's synchronous reset.

## Interface
- `DB_CYCLES`, 1000000: consecutive stable samples required to accept a new button level (10 ms at 100 MHz); must be ≥ 2.
- `LONG_CYCLES`, 200000000: run-button hold length that counts as a long press (2 s at 100 MHz); must be > `DB_CYCLES`.
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: asynchronous, active-high reset; one clock domain, `clk`.
- `btn_run` input 1: raw run/stop pushbutton, asynchronous, active-high, bouncy.
- `btn_dir` input 1: raw direction pushbutton, asynchronous, active-high, bouncy.
- `enable` output 1: count enable level; toggles on each accepted run press.
- `dir` output 1: 0 = up, 1 = down; toggles on each accepted dir press.
- `run_db` output 1: debounced run button level.
- `dir_db` output 1: debounced dir button level.
- `clr` output 1: one-cycle clear pulse. Tied 0 unless the long-press feature is compiled in.

## Operation
- Per button, identical channel:
  - 2-flop synchroniser (`s1`, `s2`).
  - Debounced level `db`.
  - Debounce counter `cnt`, width `$clog2(DB_CYCLES+1)`.
  - Registered previous level `db_q`, used for edge detection.
- Debounce rules:
  - If `s2 == db`: `cnt` <= 0.
  - Otherwise `cnt` increments.
  - On the `DB_CYCLES`-th consecutive edge with `s2 != db`: `db` <= `s2`, `cnt` <= 0.
  - Any sample where `s2` returns to `db` restarts the count.
- Press event: `db & ~db_q`. Release event: `~db & db_q`.
- `dir` toggles on each dir press event.
- `enable` toggles on each run press event (feature off).
- Run and dir channels are fully independent. Simultaneous events on both are each honoured in the same cycle.
- Counters saturate; no wrap-around is permitted.
- Reset values:
  - `enable`, `dir`, `run_db`, `dir_db`, `clr` = 0.
  - All synchroniser flops, `db`, `db_q` and counters = 0.
- Reset asserted mid-operation clears everything immediately, without waiting for `clk`. A debounce in progress is discarded.

## Timing
- Output latency:
  - Pin rise is first captured at edge E0 (the first rising edge after the pin changes).
  - `s2` = 1 after E1.
  - `db` = 1 after E(1+`DB_CYCLES`).
  - `enable`/`dir` flip after E(2+`DB_CYCLES`).
  - Total: the (`DB_CYCLES`+3)-th rising edge counted from the first capture edge.
- `run_db`/`dir_db` are `db` directly and lead the toggled outputs by one cycle.
- `clr` is registered and high for exactly one cycle per long press.
- All outputs are flop outputs; there is no combinational path from inputs.
- Reset release: the first sample is taken on the first `clk` edge after `reset` falls.

## Configuration
- Macro: `BUTTON_CTRL_LONGPRESS_EN`.
- Defined:
  - Run channel adds a hold counter `hold`, width `$clog2(LONG_CYCLES+1)`. It clears when `run_db` = 0 and increments (saturating at `LONG_CYCLES`) while `run_db` = 1.
  - When `hold` reaches `LONG_CYCLES`, on the next edge: `clr` = 1 for one cycle, `enable` <= 0, `dir` <= 0.
  - `enable` toggles on the run **release** event, and only if `hold` < `LONG_CYCLES` at release.
  - Press events no longer toggle `enable`.
  - A dir press that coincides with the clr cycle is overridden: `dir` = 0.
- Undefined:
  - `hold` logic is absent.
  - `clr` is tied 0.
  - `enable` toggles on press as described in Operation.

## Test plan
Bench parameters: `DB_CYCLES`=4, `LONG_CYCLES`=20.
- Reset with buttons idle -> all outputs 0. Assert `reset` between edges -> outputs 0 before the next edge.
- `btn_run` high for 3 cycles then low, repeated bursts of 1–3 cycles -> `run_db` and `enable` stay 0 throughout.
- Feature off: `btn_run` held high for 10 cycles -> `run_db` = 1 after the 6th edge and `enable` = 1 after the 7th. A second clean press -> `enable` = 0.
- `btn_run` and `btn_dir` rise together and hold for 10 cycles -> `enable` and `dir` both become 1 on the same edge. A dir-only press -> `dir` = 0 and `enable` unchanged.
- Feature on, long press:
  - `enable`=1, `dir`=1; hold `btn_run` for 30 cycles -> one `clr` pulse, `enable` = `dir` = 0. Release -> no toggle.
  - Then hold for 10 cycles -> `enable` = 1 one cycle after `run_db` falls.
- Assert `reset` while `btn_dir` has been stable for 3 of 4 debounce samples, release `reset`, hold the button -> the full 4-sample debounce restarts and `dir` toggles 7 edges after reset release.

Source files
------------

// File: rtl/button_ctrl.sv
// Two-button front-panel conditioner: synchronise, debounce, and turn presses into enable/dir levels.
// Optional long-press clear on the run button is built when BUTTON_CTRL_LONGPRESS_EN is defined.
module button_ctrl #(
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 200000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_dir,
  output logic enable,
  output logic dir,
  output logic run_db,
  output logic dir_db,
  output logic clr
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  // Channel 0 is run, channel 1 is dir.
  logic [1:0] btn_raw;
  logic [1:0] db_w;
  logic [1:0] db_prev_w;

  assign btn_raw = {btn_dir, btn_run};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          db_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count only survives while every sample disagrees with the accepted level.
    always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      if (s2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q >= DB_LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        s1_q      <= btn_raw[gi];
        s2_q      <= s1_q;
        db_q      <= db_d;
        db_prev_q <= db_q;
        cnt_q     <= cnt_d;
      end
    end

    assign db_w[gi]      = db_q;
    assign db_prev_w[gi] = db_prev_q;
  end

  logic enable_q;
  logic enable_d;
  logic dir_q;
  logic dir_d;
  logic dir_press;

  assign dir_press = db_w[1] & ~db_prev_w[1];

`ifdef BUTTON_CTRL_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          long_q;
  logic          long_d;
  logic          clr_q;
  logic          clr_d;
  logic          run_release;
  logic          long_fire;

  assign run_release = ~db_w[0] & db_prev_w[0];
  // long_q remembers that hold already sat at its ceiling, so the clear fires once per hold.
  assign long_fire   = (hold_q == HOLD_MAX) && !long_q;

  always_comb begin
    enable_d = enable_q;
    dir_d    = dir_q;
    clr_d    = 1'b0;
    hold_d   = '0;
    long_d   = (hold_q == HOLD_MAX);
    if (db_w[0]) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    end
    if (dir_press) begin
      dir_d = ~dir_q;
    end
    if (run_release && (hold_q < HOLD_MAX)) begin
      enable_d = ~enable_q;
    end
    if (long_fire) begin
      clr_d    = 1'b1;
      enable_d = 1'b0;
      dir_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
      clr_q  <= clr_d;
    end
  end

  assign clr = clr_q;
`else
  logic run_press;

  assign run_press = db_w[0] & ~db_prev_w[0];

  always_comb begin
    enable_d = enable_q;
    dir_d    = dir_q;
    if (run_press) begin
      enable_d = ~enable_q;
    end
    if (dir_press) begin
      dir_d = ~dir_q;
    end
  end

  assign clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      dir_q    <= dir_d;
    end
  end

  assign enable = enable_q;
  assign dir    = dir_q;
  assign run_db = db_w[0];
  assign dir_db = db_w[1];

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with DB_CYCLES=4, LONG_CYCLES=20; expectations are queued
// against absolute cycle numbers and checked as each cycle completes.
module tb_button_ctrl;

`ifdef BUTTON_CTRL_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_run;
  logic btn_dir;
  logic enable;
  logic dir;
  logic run_db;
  logic dir_db;
  logic clr;
  logic [4:0] obs;

  button_ctrl #(
    .DB_CYCLES  (4),
    .LONG_CYCLES(20)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_run(btn_run),
    .btn_dir(btn_dir),
    .enable (enable),
    .dir    (dir),
    .run_db (run_db),
    .dir_db (dir_db),
    .clr    (clr)
  );

  always #5 clk = ~clk;

  // {enable, dir, run_db, dir_db, clr}
  assign obs = {enable, dir, run_db, dir_db, clr};

  typedef struct {
    int         cyc;
    logic [4:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  int   c;
  int   c2;
  int   r;
  int   burst[7] = '{3, 1, 1, 1, 2, 2, 3};

  function automatic logic [4:0] o5(input bit en, input bit d, input bit rdb, input bit ddb, input bit cl);
    return {en, d, rdb, ddb, cl};
  endfunction

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic expect_at(input int at, input logic [4:0] e, input string tag);
    sb.push_back('{at, e, tag});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        chk(sb[i].tag, obs, sb[i].exp);
        sb.delete(i);
      end
    end
    $display("cycle %0d run=%b dir_btn=%b out{en,dir,rdb,ddb,clr}=%b", cyc, btn_run, btn_dir, obs);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset   = 1'b1;
    btn_run = 1'b0;
    btn_dir = 1'b0;
    cyc     = 0;
    checks  = 0;
    errors  = 0;

    ticks(3);
    chk("reset_state", obs, 5'b0);
    reset = 1'b0;

    // Bursts of at most 3 samples never reach the 4-sample threshold.
    for (int i = 0; i < 7; i++) begin
      btn_run = (i % 2 == 0);
      for (int k = 0; k < burst[i]; k++) begin
        expect_at(cyc + 1, o5(0, 0, 0, 0, 0), "glitch");
        tick();
      end
    end
    btn_run = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_at(cyc + 1, o5(0, 0, 0, 0, 0), "glitch_tail");
      tick();
    end

    // First clean run press.
    c = cyc;
    btn_run = 1'b1;
    expect_at(c + 5, o5(0, 0, 0, 0, 0), "run_db_early");
    expect_at(c + 6, o5(0, 0, 1, 0, 0), "run_db_rise");
    expect_at(c + 7, o5(!LP, 0, 1, 0, 0), "run_press_en");
    ticks(10);
    btn_run = 1'b0;
    c2 = cyc;
    expect_at(c2 + 5, o5(!LP, 0, 1, 0, 0), "run_db_hold");
    expect_at(c2 + 6, o5(!LP, 0, 0, 0, 0), "run_db_fall");
    expect_at(c2 + 7, o5(1, 0, 0, 0, 0), "run_en_after1");
    ticks(10);

    // Second clean run press turns enable back off.
    c = cyc;
    btn_run = 1'b1;
    expect_at(c + 7, o5(LP, 0, 1, 0, 0), "run2_press_en");
    ticks(10);
    btn_run = 1'b0;
    c2 = cyc;
    expect_at(c2 + 7, o5(0, 0, 0, 0, 0), "run_en_after2");
    ticks(10);

    // Both buttons together: independent channels, same-edge effects.
    c = cyc;
    btn_run = 1'b1;
    btn_dir = 1'b1;
    expect_at(c + 6, o5(0, 0, 1, 1, 0), "both_db");
    expect_at(c + 7, o5(!LP, 1, 1, 1, 0), "both_toggle");
    ticks(10);
    btn_run = 1'b0;
    btn_dir = 1'b0;
    c2 = cyc;
    expect_at(c2 + 7, o5(1, 1, 0, 0, 0), "both_release");
    ticks(10);

    // Dir-only press leaves enable untouched.
    c = cyc;
    btn_dir = 1'b1;
    expect_at(c + 7, o5(1, 0, 0, 1, 0), "dir_only_press");
    ticks(10);
    btn_dir = 1'b0;
    c2 = cyc;
    expect_at(c2 + 7, o5(1, 0, 0, 0, 0), "dir_only_release");
    ticks(10);

    // Set dir back to 1 ahead of the long press.
    c = cyc;
    btn_dir = 1'b1;
    expect_at(c + 7, o5(1, 1, 0, 1, 0), "dir_set");
    ticks(10);
    btn_dir = 1'b0;
    ticks(10);

    // 30-cycle run hold: clear pulse only when the long-press feature is built.
    c = cyc;
    btn_run = 1'b1;
    expect_at(c + 26, o5(LP, 1, 1, 0, 0), "long_before");
    expect_at(c + 27, o5(0, !LP, 1, 0, LP), "long_clr");
    expect_at(c + 28, o5(0, !LP, 1, 0, 0), "long_clr_once");
    ticks(30);
    btn_run = 1'b0;
    c2 = cyc;
    expect_at(c2 + 7, o5(0, !LP, 0, 0, 0), "long_release");
    ticks(10);

    // Short hold afterwards: enable comes back on.
    c = cyc;
    btn_run = 1'b1;
    ticks(10);
    btn_run = 1'b0;
    c2 = cyc;
    expect_at(c2 + 6, o5(!LP, !LP, 0, 0, 0), "short_db_fall");
    expect_at(c2 + 7, o5(1, !LP, 0, 0, 0), "short_en");
    ticks(10);

    // Reset between edges with dir debounce 3 of 4 samples in.
    c = cyc;
    btn_dir = 1'b1;
    ticks(5);
    reset = 1'b1;
    #2;
    chk("async_reset", obs, 5'b0);
    tick();
    chk("reset_held", obs, 5'b0);
    reset = 1'b0;
    r = cyc;
    expect_at(r + 5, o5(0, 0, 0, 0, 0), "restart_no_early");
    expect_at(r + 6, o5(0, 0, 0, 1, 0), "restart_dir_db");
    expect_at(r + 7, o5(0, 1, 0, 1, 0), "restart_dir_toggle");
    ticks(8);
    btn_dir = 1'b0;
    ticks(10);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
